spi_burst_feeder: RTL and testbench

//  Upstream stage of the SPI master controller. Buffers host bytes in a FIFO, then issues

---
 rtl/spi_burst_feeder.sv | 187 ++++++++++++++++++
 tb/tb_spi_burst_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_feeder
// Brief    : Host-side byte FIFO feeding an SPI master as one chip-select
//            burst. Issues byte count plus DV-pulsed bytes paced by the
//            master's ready, forwards returned MISO bytes, flags completion.
// Revision : 1.0 - initial release
// ============================================================================
module spi_burst_feeder #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int FIFO_DEPTH       = 8,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Wr_Ready,
  output logic [AW:0]   o_Fifo_Count,
  input  logic          i_Burst_Start,
  input  logic [CW-1:0] i_Burst_Len,
  output logic          o_Busy,
  output logic [CW-1:0] o_TX_Count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic          o_Burst_Done,
  output logic          o_Burst_Err
);

  // Width wide enough to compare a burst length against the FIFO fill level
  localparam int XW = (CW > AW + 1) ? CW : AW + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RX  = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] remaining;
  logic [CW-1:0] rx_cnt;

  logic          full;
  logic          push;
  logic          pop;
  logic          load;
  logic          reject;
  logic          rx_take;
  logic          go_done;
  logic          len_ok;

  // FIFO status; a full FIFO still accepts a write in a cycle where the head
  // is being popped, so the slot being freed is reused and nothing is lost
  always_comb begin
    full       = (o_Fifo_Count == (AW + 1)'(FIFO_DEPTH));
    o_Wr_Ready = !full || pop;
    push       = i_Wr_DV && o_Wr_Ready;
    len_ok     = (i_Burst_Len != '0) &&
                 (32'(i_Burst_Len) <= 32'(MAX_BYTES_PER_CS)) &&
                 (XW'(i_Burst_Len) <= XW'(o_Fifo_Count));
    o_Busy     = (state != IDLE);
  end

  // Burst FSM state register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Burst FSM next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    reject    = 1'b0;
    rx_take   = 1'b0;
    go_done   = 1'b0;
    case (state)
      IDLE: begin
        if (i_Burst_Start) begin
          if (len_ok) begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (i_TX_Ready && (remaining != '0)) begin
          pop       = 1'b1;
          state_nxt = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (i_RX_DV) begin
          rx_take = 1'b1;
          if ((rx_cnt + CW'(1)) == o_TX_Count) begin
            go_done   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        // Master must re-raise ready after its RX DV before the next byte
        if (i_TX_Ready) state_nxt = ISSUE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FIFO storage; pointers alone define contents, so no reset is needed
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= i_Wr_Byte;
  end

  // FIFO pointers/count, TX/RX output registers and burst bookkeeping
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_Fifo_Count <= '0;
      o_TX_Count   <= '0;
      o_TX_Byte    <= '0;
      o_TX_DV      <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Burst_Done <= 1'b0;
      o_Burst_Err  <= 1'b0;
      remaining    <= '0;
      rx_cnt       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   o_Fifo_Count <= o_Fifo_Count + (AW + 1)'(1);
        2'b01:   o_Fifo_Count <= o_Fifo_Count - (AW + 1)'(1);
        default: o_Fifo_Count <= o_Fifo_Count;
      endcase

      o_TX_DV <= pop;
      if (pop) begin
        o_TX_Byte <= mem[rd_ptr];
        remaining <= remaining - CW'(1);
      end

      if (load) begin
        o_TX_Count <= i_Burst_Len;
        remaining  <= i_Burst_Len;
        rx_cnt     <= '0;
      end else if (state == DONE) begin
        o_TX_Count <= '0;
      end

      if (rx_take) begin
        rx_cnt    <= rx_cnt + CW'(1);
        o_RX_Byte <= i_RX_Byte;
      end
      o_RX_DV      <= rx_take;
      o_Burst_Done <= go_done;
      o_Burst_Err  <= reject;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_feeder
// Brief    : Directed self-checking bench for spi_burst_feeder, with the
//            SPI master's ready/RX handshake driven by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_burst_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_dv;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic [3:0] fifo_count;
  logic       burst_start;
  logic [1:0] burst_len;
  logic       busy;
  logic [1:0] tx_count;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv_in;
  logic [7:0] rx_byte_in;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       burst_done;
  logic       burst_err;

  int errors   = 0;
  int checks   = 0;
  int dv_cnt   = 0;
  int done_cnt = 0;
  int snap;

  // 100 MHz clock
  always #5 clk = ~clk;

  spi_burst_feeder #(.MAX_BYTES_PER_CS(2), .FIFO_DEPTH(8)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Wr_DV       (wr_dv),
    .i_Wr_Byte     (wr_byte),
    .o_Wr_Ready    (wr_ready),
    .o_Fifo_Count  (fifo_count),
    .i_Burst_Start (burst_start),
    .i_Burst_Len   (burst_len),
    .o_Busy        (busy),
    .o_TX_Count    (tx_count),
    .o_TX_Byte     (tx_byte),
    .o_TX_DV       (tx_dv),
    .i_TX_Ready    (tx_ready),
    .i_RX_DV       (rx_dv_in),
    .i_RX_Byte     (rx_byte_in),
    .o_RX_DV       (rx_dv),
    .o_RX_Byte     (rx_byte),
    .o_Burst_Done  (burst_done),
    .o_Burst_Err   (burst_err)
  );

  // Count TX DV and Done pulses as seen at each rising edge
  always @(posedge clk) begin
    if (tx_dv)      dv_cnt   = dv_cnt + 1;
    if (burst_done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_dv   = 1'b1;
    wr_byte = b;
    tick();
    wr_dv   = 1'b0;
  endtask

  task automatic reject(input int len);
    burst_len   = 2'(len);
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    check("err_pulse", burst_err, 1);
    check("err_idle", busy, 0);
    tick();
    check("err_drop", burst_err, 0);
  endtask

  // Play the master for an accepted burst: take each DV byte, return RX bytes
  task automatic serve(input int len, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] r0, input logic [7:0] r1);
    for (int k = 0; k < len; k++) begin
      int n = 0;
      while (!tx_dv && n < 50) begin
        tick();
        n++;
      end
      if (!tx_dv) begin
        check("dv_wait", 0, 1);
        return;
      end
      check("tx_byte", tx_byte, (k == 0) ? e0 : e1);
      check("tx_count_held", tx_count, len);
      tx_ready = 1'b0;
      tick();
      check("dv_one_cycle", tx_dv, 0);
      rx_dv_in   = 1'b1;
      rx_byte_in = (k == 0) ? r0 : r1;
      tick();
      rx_dv_in   = 1'b0;
      check("rx_dv", rx_dv, 1);
      check("rx_byte", rx_byte, (k == 0) ? r0 : r1);
      if (k == len - 1) begin
        check("done_pulse", burst_done, 1);
      end else begin
        check("done_early", burst_done, 0);
        tx_ready = 1'b1;
      end
    end
    tick();
    check("done_drop", burst_done, 0);
    check("idle_after", busy, 0);
    check("tx_count_clr", tx_count, 0);
  endtask

  task automatic burst(input int len, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] r0, input logic [7:0] r1,
                       input bit wr_during, input logic [7:0] wb);
    tx_ready    = 1'b1;
    burst_len   = 2'(len);
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    check("busy_start", busy, 1);
    check("tx_count_load", tx_count, len);
    if (wr_during) begin
      wr_dv   = 1'b1;
      wr_byte = wb;
      #1;
      check("wr_ready_on_pop", wr_ready, 1);
      tick();
      wr_dv = 1'b0;
      check("count_push_pop", fifo_count, 8);
    end
    serve(len, e0, e1, r0, r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    wr_dv       = 1'b0;
    wr_byte     = '0;
    burst_start = 1'b0;
    burst_len   = '0;
    tx_ready    = 1'b0;
    rx_dv_in    = 1'b0;
    rx_byte_in  = '0;
    repeat (3) tick();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_count", tx_count, 0);
    rst_n = 1'b1;
    tick();

    // Basic two-byte burst
    write_byte(8'hA5);
    write_byte(8'h3C);
    check("count_two", fifo_count, 2);
    burst(2, 8'hA5, 8'h3C, 8'h11, 8'h22, 1'b0, 8'h00);
    check("done_cnt_1", done_cnt, 1);

    // Rejected starts
    write_byte(8'h77);
    snap = dv_cnt;
    reject(3);
    reject(0);
    reject(2);
    check("reject_no_dv", dv_cnt, snap);
    check("reject_count", fifo_count, 1);
    write_byte(8'h88);
    burst(2, 8'h77, 8'h88, 8'h5A, 8'hA5, 1'b0, 8'h00);

    // Fill past capacity, then pop across the pointer wrap
    for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i));
    check("full_count", fifo_count, 8);
    check("full_not_ready", wr_ready, 0);
    burst(2, 8'h10, 8'h11, 8'h01, 8'h02, 1'b1, 8'h19);
    check("count_after_b1", fifo_count, 7);
    burst(2, 8'h12, 8'h13, 8'h03, 8'h04, 1'b0, 8'h00);
    burst(2, 8'h14, 8'h15, 8'h05, 8'h06, 1'b0, 8'h00);
    burst(2, 8'h16, 8'h17, 8'h07, 8'h08, 1'b0, 8'h00);
    check("count_one_left", fifo_count, 1);

    // Spurious RX DV in IDLE, then ready held low in ISSUE
    rx_dv_in   = 1'b1;
    rx_byte_in = 8'hEE;
    tick();
    rx_dv_in   = 1'b0;
    check("spurious_rx", rx_dv, 0);
    write_byte(8'h2A);
    tx_ready    = 1'b0;
    burst_len   = 2'd2;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    snap = dv_cnt;
    repeat (20) tick();
    check("stall_no_dv", dv_cnt, snap);
    check("stall_busy", busy, 1);
    check("stall_count", fifo_count, 2);
    tx_ready = 1'b1;
    serve(2, 8'h19, 8'h2A, 8'h33, 8'h44);

    // Asynchronous reset mid-burst
    write_byte(8'h31);
    write_byte(8'h32);
    tx_ready    = 1'b1;
    burst_len   = 2'd2;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    tick();
    check("pre_rst_dv", tx_dv, 1);
    check("pre_rst_byte", tx_byte, 8'h31);
    snap  = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_dv", tx_dv, 0);
    check("arst_byte", tx_byte, 0);
    check("arst_tx_count", tx_count, 0);
    check("arst_busy", busy, 0);
    check("arst_count", fifo_count, 0);
    check("arst_wr_ready", wr_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_done", done_cnt, snap);
    check("arst_no_err", burst_err, 0);
    write_byte(8'h41);
    write_byte(8'h42);
    burst(2, 8'h41, 8'h42, 8'h55, 8'h66, 1'b0, 8'h00);
    check("done_total", done_cnt, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
